// File: rtl/temporizador_multi_pkg.sv
// temporizador_pkg: register map and CTRL bit positions shared by the timer slice.
package temporizador_pkg;
    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_HIGH     = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam int         CTRL_EN      = 0;
    localparam int         CTRL_ONESHOT = 1;
endpackage

// File: rtl/temporizador_multi_if.sv
// temporizador_multi_if: CPU write port and per-channel timer outputs.
interface temporizador_multi_if #(
    parameter int NCH     = 2,
    parameter int WIDTH   = 16,
    parameter int CH_BITS = 1
);
    logic               wr_en;
    logic [CH_BITS+1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     running;
    logic [NCH-1:0]     done;
    modport master (output wr_en, wr_addr, wr_data, input clk_out, tick, running, done);
    modport slave  (input wr_en, wr_addr, wr_data, output clk_out, tick, running, done);
endinterface

// File: rtl/temporizador_multi_canal.sv
// temporizador_canal: one timer channel with shadowed period/high time and periodic or one-shot mode.
module temporizador_canal
    import temporizador_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [1:0]       wr_off_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             running_o,
    output logic             done_o
);
    localparam logic [WIDTH-1:0] DP = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DH = WIDTH'(DEFAULT_PERIOD / 2);

    logic [WIDTH-1:0] per_sh_q, per_sh_d, high_sh_q, high_sh_d;
    logic [WIDTH-1:0] per_q, per_d, high_q, high_d, cnt_q, cnt_d;
    logic             run_q, run_d, os_q, os_d, done_q, done_d, clk_q, tick_q;
    logic             wr_per, wr_high, wr_ctrl, wrap;

    // Last count of a period; periods below 2 are treated as 2.
    function automatic logic [WIDTH-1:0] last_cnt(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(1) : p - WIDTH'(1);
    endfunction

    assign wr_per  = wr_en_i && wr_off_i == REG_PERIOD;
    assign wr_high = wr_en_i && wr_off_i == REG_HIGH;
    assign wr_ctrl = wr_en_i && wr_off_i == REG_CTRL;
    assign wrap    = run_q && cnt_q == last_cnt(per_q);

    always_comb begin
        per_sh_d  = wr_per  ? wr_data_i : per_sh_q;
        high_sh_d = wr_high ? wr_data_i : high_sh_q;
        per_d     = per_q;
        high_d    = high_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        os_d      = os_q;
        done_d    = done_q;
        if (wr_ctrl) begin
            os_d  = wr_data_i[CTRL_ONESHOT];
            run_d = wr_data_i[CTRL_EN];
            cnt_d = '0;
            if (wr_data_i[CTRL_EN]) begin
                done_d = 1'b0;
                per_d  = per_sh_d;
                high_d = high_sh_d;
            end
        end else if (wrap) begin
            cnt_d = '0;
            if (os_q) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                per_d  = per_sh_d;
                high_d = high_sh_d;
            end
        end else if (run_q) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Outputs are registered from next-state values so they line up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh_q  <= DP;
            high_sh_q <= DH;
            per_q     <= DP;
            high_q    <= DH;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            os_q      <= 1'b0;
            done_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            per_sh_q  <= per_sh_d;
            high_sh_q <= high_sh_d;
            per_q     <= per_d;
            high_q    <= high_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            os_q      <= os_d;
            done_q    <= done_d;
            clk_q     <= run_d && cnt_d < high_d;
            tick_q    <= run_d && cnt_d == last_cnt(per_d);
        end
    end

    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;
    assign running_o = run_q;
    assign done_o    = done_q;
endmodule

// File: rtl/temporizador_multi.sv
// temporizador_multi: NCH independent programmable dividers behind a single CPU write port.
module temporizador_multi
    import temporizador_pkg::*;
#(
    parameter int NCH            = 2,
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int CH_BITS        = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    temporizador_multi_if.slave  bus
);
    logic [CH_BITS-1:0] ch;
    logic [1:0]         off;
    logic [NCH-1:0]     co, tk, rn, dn;

    assign ch  = bus.wr_addr[CH_BITS+1:2];
    assign off = bus.wr_addr[1:0];

    // Indices at or above NCH match no channel and are dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        temporizador_canal #(
            .WIDTH         (WIDTH),
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
        ) u_canal (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (bus.wr_en && ch == CH_BITS'(g)),
            .wr_off_i (off),
            .wr_data_i(bus.wr_data),
            .clk_out_o(co[g]),
            .tick_o   (tk[g]),
            .running_o(rn[g]),
            .done_o   (dn[g])
        );
    end

    assign bus.clk_out = co;
    assign bus.tick    = tk;
    assign bus.running = rn;
    assign bus.done    = dn;
endmodule

// File: tb/tb_temporizador_multi.sv
// tb_temporizador_multi: directed test-plan scenarios plus random writes against a behavioural timer model.
module tb_temporizador_multi;
    localparam int NCH = 3, W = 8, DP = 10, CB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    temporizador_multi_if #(.NCH(NCH), .WIDTH(W), .CH_BITS(CB)) bus ();
    temporizador_multi #(.NCH(NCH), .WIDTH(W), .DEFAULT_PERIOD(DP), .CH_BITS(CB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vecs = 0, errs = 0;
    int m_psh[NCH], m_hsh[NCH], m_p[NCH], m_h[NCH], m_cnt[NCH];
    bit m_run[NCH], m_done[NCH], m_os[NCH];

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        vecs++;
        if (got !== 32'(exp)) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int p);
        return p < 2 ? 2 : p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_psh[c] = DP; m_hsh[c] = DP / 2; m_p[c] = DP; m_h[c] = DP / 2;
            m_cnt[c] = 0; m_run[c] = 0; m_done[c] = 0; m_os[c] = 0;
        end
    endtask

    // One clock edge: a period lasts eff(P) cycles; boundaries reload from shadow; CTRL writes win.
    task automatic model_edge(input bit we, input int addr, input int data);
        int c, off;
        bit end_of_period;
        c = addr / 4;
        off = addr % 4;
        if (!we || c >= NCH) return;
        end_of_period = m_run[c] && m_cnt[c] + 1 == eff(m_p[c]);
        if (off == 0) m_psh[c] = data;
        if (off == 1) m_hsh[c] = data;
        if (off == 2) begin
            m_run[c] = data[0];
            m_os[c] = data[1];
            m_cnt[c] = 0;
            if (data[0]) begin
                m_done[c] = 0; m_p[c] = m_psh[c]; m_h[c] = m_hsh[c];
            end
            end_of_period = 0;
            data = -1;
        end
        if (data != -1) advance(c, end_of_period);
    endtask

    task automatic advance(input int c, input bit eop);
        if (!m_run[c]) return;
        if (!eop) begin
            m_cnt[c]++;
        end else if (m_os[c]) begin
            m_run[c] = 0; m_done[c] = 1; m_cnt[c] = 0;
        end else begin
            m_cnt[c] = 0; m_p[c] = m_psh[c]; m_h[c] = m_hsh[c];
        end
    endtask

    task automatic step_all(input bit we, input int addr, input int data);
        int wc;
        wc = we ? addr / 4 : -1;
        if (we && wc < NCH) model_edge(we, addr, data);
        for (int c = 0; c < NCH; c++)
            if (c != wc) advance(c, m_run[c] && m_cnt[c] + 1 == eff(m_p[c]));
    endtask

    task automatic check_all();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("clk_out%0d", c), bus.clk_out[c], int'(m_run[c] && m_cnt[c] < m_h[c]));
            chk($sformatf("tick%0d", c), bus.tick[c], int'(m_run[c] && m_cnt[c] == eff(m_p[c]) - 1));
            chk($sformatf("running%0d", c), bus.running[c], int'(m_run[c]));
            chk($sformatf("done%0d", c), bus.done[c], int'(m_done[c]));
        end
    endtask

    task automatic cyc(input bit we, input int addr, input int data);
        bus.wr_en = we;
        bus.wr_addr = (CB + 2)'(addr);
        bus.wr_data = W'(data);
        @(posedge clk);
        step_all(we, addr, data & 8'hff);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check_all();
    endtask

    task automatic wr(input int c, input int off, input int data);
        cyc(1'b1, c * 4 + off, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0);
    endtask

    initial begin
        int a, d;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("reset_outs", {bus.clk_out, bus.tick, bus.running, bus.done}, 0);

        wr(0, 0, 4); wr(0, 1, 2); wr(0, 2, 1);
        for (int i = 0; i < 8; i++) begin
            chk("t1_clk", bus.clk_out[0], int'((i % 4) < 2));
            chk("t1_tick", bus.tick[0], int'((i % 4) == 3));
            chk("t1_run", bus.running[0], 1);
            idle(1);
        end

        wr(0, 0, 5); wr(0, 1, 0); idle(12);
        for (int i = 0; i < 10; i++) begin
            chk("t2_clk0", bus.clk_out[0], 0);
            idle(1);
        end
        wr(0, 1, 7); idle(12);
        for (int i = 0; i < 5; i++) begin
            chk("t2_clk1", bus.clk_out[0], 1);
            idle(1);
        end

        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                wr(1, 0, 3); wr(1, 1, 1);
            end
            wr(1, 2, 3);
            for (int i = 0; i < 3; i++) begin
                chk("t3_clk", bus.clk_out[1], int'(i == 0));
                chk("t3_tick", bus.tick[1], int'(i == 2));
                chk("t3_done", bus.done[1], 0);
                idle(1);
            end
            chk("t3_run_end", bus.running[1], 0);
            chk("t3_done_end", bus.done[1], 1);
            idle(3);
        end

        wr(0, 1, 2); wr(0, 0, 4); wr(0, 2, 1); idle(1);
        wr(0, 0, 6); idle(20);

        wr(1, 0, 7); wr(1, 2, 1); idle(5);
        #2 rst_n = 1'b0;
        #1 chk("t5_async", {bus.clk_out, bus.tick, bus.running, bus.done}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        wr(0, 2, 1); idle(12);
        wr(0, 0, 1); idle(14);

        wr(3, 0, 1); wr(3, 2, 1); wr(0, 3, 0); wr(1, 3, 1); idle(6);

        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 15);
            d = (a % 4 == 2) ? $urandom_range(0, 3) : $urandom_range(0, 12);
            cyc($urandom_range(0, 3) == 0, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
